memory_stage: RTL and testbench

//  Pipeline MEM stage, directly downstream of execute; consumes ALUResultM/WriteDataM from the EX/MEM register.

---
 rtl/memory_stage.sv | 133 +++++++++++++
 tb/tb_memory_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage driving a req/ack data-memory port with byte-lane stores and extended loads.
// Optional bus timeout abort is enabled by defining MEM_TIMEOUT_EN.
module memory_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  BusErrM
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                r_state, w_next;
    logic                  r_req, r_we;
    logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_rdata;
    logic [3:0]            r_be;
    logic [2:0]            r_f3;
    logic [1:0]            r_lane;

    logic                  w_is_b, w_is_h, w_is_w, w_access, w_mis, w_start, w_timeout;
    logic                  w_ld_b, w_ld_h;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata, w_load;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    assign w_is_b   = (Funct3M == 3'b000) || (Funct3M == 3'b100);
    assign w_is_h   = (Funct3M == 3'b001) || (Funct3M == 3'b101);
    assign w_is_w   = !(w_is_b || w_is_h);
    assign w_access = MemReadM || MemWriteM;
    assign w_mis    = (w_is_h && ALUResultM[0]) || (w_is_w && (ALUResultM[1:0] != 2'b00));
    assign w_start  = (r_state == IDLE) && w_access && !w_mis;

    assign w_be    = w_is_b ? 4'b0001 << ALUResultM[1:0] : w_is_h ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = w_is_b ? {4{WriteDataM[7:0]}} : w_is_h ? {2{WriteDataM[15:0]}} : WriteDataM;

    // Load extraction uses the size and lane captured at issue, since the address bus is word aligned.
    assign w_ld_b = (r_f3 == 3'b000) || (r_f3 == 3'b100);
    assign w_ld_h = (r_f3 == 3'b001) || (r_f3 == 3'b101);
    assign w_byte = dmem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign w_load = w_ld_b ? {{24{!r_f3[2] && w_byte[7]}}, w_byte}
                  : w_ld_h ? {{16{!r_f3[2] && w_half[15]}}, w_half} : dmem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? BUSY : IDLE;
            BUSY:    w_next = (dmem_ack || w_timeout) ? DONE : BUSY;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= 4'b0000;
            r_f3    <= 3'b000;
            r_lane  <= 2'b00;
            r_rdata <= '0;
        end else if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteM;
            r_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_f3    <= Funct3M;
            r_lane  <= ALUResultM[1:0];
        end else if (r_state == BUSY && dmem_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_rdata <= w_load;
        end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_rdata <= '0;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_buserr;

    // An ack on the final BUSY cycle takes priority over the abort.
    assign w_timeout = (r_state == BUSY) && !dmem_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_buserr <= 1'b0;
        end else begin
            r_cnt    <= w_start ? '0 : (r_state == BUSY) ? r_cnt + CW'(1) : r_cnt;
            r_buserr <= w_timeout ? 1'b1 : (r_state == DONE) ? 1'b0 : r_buserr;
        end
    end

    assign BusErrM = r_buserr;
`else
    assign w_timeout = TIMEOUT_CYCLES < 0;
    assign BusErrM   = 1'b0;
`endif

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign ReadDataM  = r_rdata;
    assign StallM     = w_start || (r_state == BUSY);
    assign MisalignM  = (r_state == IDLE) && w_access && w_mis;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed bench for memory_stage with a transaction-level reference model.
module tb_memory_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, dmem_ack = 1'b0;
    logic [2:0]  Funct3M = 3'b010;
    logic [31:0] ALUResultM = '0, WriteDataM = '0, dmem_rdata = '0;
    logic        dmem_req, dmem_we, StallM, MisalignM, BusErrM;
    logic [31:0] dmem_addr, dmem_wdata, ReadDataM;
    logic [3:0]  dmem_be;

    always #5 clk = ~clk;

    memory_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    int          checks = 0, errors = 0;
    int          stall_cnt = 0, req_cnt = 0, mis_cnt = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_mis = 1'b0, exp_we = 1'b0, exp_berr = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rd = '0;
    logic [3:0]  exp_be = '0;
    logic [3:0]  cap_be = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, mask;
        int sz = m_size(f3);
        v = rd >> (8 * a[1:0]);
        if (sz < 4) begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("stall", StallM, exp_stall);
            chk("req", dmem_req, exp_req);
            chk("misalign", MisalignM, exp_mis);
            chk("readdata", ReadDataM, exp_rd);
            chk("buserr", BusErrM, exp_berr);
            if (exp_req) begin
                chk("addr", dmem_addr, exp_addr);
                chk("we", dmem_we, exp_we);
                chk("be", dmem_be, exp_be);
                if (exp_we) chk("wdata", dmem_wdata, exp_wdata);
            end
            if (StallM) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                cap_be = dmem_be;
                cap_wdata = dmem_wdata;
                cap_we = dmem_we;
            end
            if (MisalignM) mis_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rdat, input int dly);
        logic acc, mis;
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
        acc = rd | wr;
        mis = acc & m_mis(f3, a);
        exp_mis = mis; exp_stall = acc & !mis; exp_req = 1'b0;
        exp_addr = {a[31:2], 2'b00}; exp_we = wr; exp_be = m_be(f3, a); exp_wdata = m_wdata(f3, wd);
        step();
        exp_mis = 1'b0;
        if (acc && !mis) begin
            exp_req = 1'b1;
            for (int k = 1; k <= dly; k++) begin
                dmem_ack = (k == dly);
                dmem_rdata = (k == dly) ? rdat : ~rdat;
                step();
            end
            dmem_ack = 1'b0;
            exp_req = 1'b0;
            exp_stall = 1'b0;
            if (!wr) exp_rd = m_load(f3, a, rdat);
            step();
        end
        MemReadM = 1'b0; MemWriteM = 1'b0;
        exp_stall = 1'b0;
    endtask

    initial begin
        int s0, r0, m0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_be", dmem_be, 4'h0);
        chk("rst_readdata", ReadDataM, 32'h0);
        chk("rst_buserr", BusErrM, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_en = 1'b1;

        s0 = stall_cnt;
        op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        chk("lw_stall_cycles", stall_cnt - s0, 2);
        chk("lw_data", ReadDataM, 32'hDEADBEEF);
        op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1);
        chk("lb_data", ReadDataM, 32'hFFFFFF80);
        op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 2);
        chk("lbu_data", ReadDataM, 32'h00000080);
        op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 1);
        chk("lh_data", ReadDataM, 32'hFFFF80FF);
        op(0, 1, 3'b000, 32'h101, 32'h123456AB, 32'h0, 1);
        chk("sb_be", cap_be, 4'b0010);
        chk("sb_wdata", cap_wdata, 32'hABABABAB);
        chk("sb_we", cap_we, 1'b1);
        chk("sb_keeps_readdata", ReadDataM, 32'hFFFF80FF);
        op(0, 1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 1);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);

        r0 = req_cnt; m0 = mis_cnt; s0 = stall_cnt;
        op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
        op(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 1);
        chk("mis_no_req", req_cnt - r0, 0);
        chk("mis_no_stall", stall_cnt - s0, 0);
        chk("mis_pulses", mis_cnt - m0, 2);

        s0 = stall_cnt;
        op(1, 0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 5);
        chk("slow_stall_cycles", stall_cnt - s0, 6);
        op(1, 1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h11111111, 1);
        chk("both_is_store", cap_we, 1'b1);
        chk("both_keeps_readdata", ReadDataM, 32'h0BADF00D);
        op(1, 0, 3'b101, 32'h106, 32'h0, 32'h9ABC1234, 1);
        chk("lhu_data", ReadDataM, 32'h00009ABC);
        op(1, 0, 3'b000, 32'h102, 32'h0, 32'h00730000, 3);
        chk("lb_pos_data", ReadDataM, 32'h00000073);
        op(1, 0, 3'b011, 32'h108, 32'h0, 32'h87654321, 1);
        chk("f3_011_as_w", ReadDataM, 32'h87654321);

        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        step();
        dmem_ack = 1'b0;
        step();
        chk("stray_ack_ignored", ReadDataM, 32'h87654321);

        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h200;
        exp_stall = 1'b1; exp_addr = 32'h200; exp_we = 1'b0; exp_be = 4'hF;
        step();
        exp_req = 1'b1;
        step();
        chk_en = 1'b0;
        MemReadM = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", dmem_req, 1'b0);
        chk("async_rst_stall", StallM, 1'b0);
        chk("async_rst_readdata", ReadDataM, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_req = 1'b0; exp_stall = 1'b0; exp_rd = 32'h0;
        step();
        chk_en = 1'b1;
        op(1, 0, 3'b010, 32'h204, 32'h0, 32'h55AA55AA, 1);
        chk("post_rst_lw", ReadDataM, 32'h55AA55AA);

`ifdef MEM_TIMEOUT_EN
        r0 = req_cnt;
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300;
        exp_stall = 1'b1; exp_addr = 32'h300; exp_we = 1'b0; exp_be = 4'hF;
        step();
        exp_req = 1'b1;
        repeat (3) step();
        exp_req = 1'b0; exp_stall = 1'b0; exp_berr = 1'b1; exp_rd = 32'h0;
        step();
        chk("timeout_buserr", BusErrM, 1'b1);
        chk("timeout_readdata", ReadDataM, 32'h0);
        MemReadM = 1'b0;
        exp_berr = 1'b0;
        step();
        chk("timeout_req_cycles", req_cnt - r0, 4);
        chk("timeout_buserr_clear", BusErrM, 1'b0);
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
